mac_layer_sched: RTL and testbench

//  Sequences one shared sequential MAC unit (start/done, sum_i(w_i*x_i)+b) to compute a full

---
 rtl/mac_layer_sched.sv | 211 +++++++++++++++++++++
 tb/tb_mac_layer_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_layer_sched.sv
// -----------------------------------------------------------------------------
// mac_layer_sched
//
// Purpose:
//   Computes a full dense layer of M neurons over one N-element input vector
//   by driving a single shared sequential MAC unit. The MAC unit has a
//   start/done handshake and computes sum_i(w_i*x_i)+b. This block latches the
//   input vector, all weights and all biases. It then issues one MAC job per
//   neuron and collects the results into the output vector y.
//
// Optional feature:
//   MAC_SCHED_RELU_EN  when defined, each neuron result is clamped at zero
//                      (ReLU) as it is stored. Timing and handshakes do not
//                      change.
//
// Ports:
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   in_valid/ready  layer job handshake (x, w_all, b_all)
//   x               N signed elements, element i at [i*WIDTH +: WIDTH]
//   w_all           M*N signed weights, neuron j at [j*N*WIDTH +: N*WIDTH]
//   b_all           M signed biases, neuron j at [j*WIDTH +: WIDTH]
//   mac_start       one-cycle start pulse to the MAC
//   mac_x/w/b       operands of the current neuron to the MAC
//   mac_done        MAC done level (held until next start)
//   mac_sum         signed MAC result, 2*WIDTH+2 bits
//   out_valid/ready layer result handshake
//   y               M signed results, neuron j at [j*(2*WIDTH+2) +: 2*WIDTH+2]
//   busy            block is not idle
// -----------------------------------------------------------------------------
module mac_layer_sched #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int M     = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N*WIDTH-1:0]         x,
  input  logic [M*N*WIDTH-1:0]       w_all,
  input  logic [M*WIDTH-1:0]         b_all,
  output logic                       mac_start,
  output logic [N*WIDTH-1:0]         mac_x,
  output logic [N*WIDTH-1:0]         mac_w,
  output logic [WIDTH-1:0]           mac_b,
  input  logic                       mac_done,
  input  logic [2*WIDTH+1:0]         mac_sum,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [M*(2*WIDTH+2)-1:0]   y,
  output logic                       busy
);

  localparam int SW = 2*WIDTH + 2;
  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  in_ready_q, in_ready_d;
  logic                  mac_start_q, mac_start_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic [N*WIDTH-1:0]    x_q, x_d;
  logic [N*WIDTH-1:0]    w_q [M];
  logic [N*WIDTH-1:0]    w_d [M];
  logic [WIDTH-1:0]      b_q [M];
  logic [WIDTH-1:0]      b_d [M];
  logic [SW-1:0]         y_q [M];
  logic [SW-1:0]         y_d [M];

  // Unpacked views of the flat weight/bias input buses.
  logic [N*WIDTH-1:0]    w_in [M];
  logic [WIDTH-1:0]      b_in [M];
  logic [SW-1:0]         store_val;

  genvar gi;
  generate
    for (gi = 0; gi < M; gi++) begin : g_neuron
      assign w_in[gi]          = w_all[gi*N*WIDTH +: N*WIDTH];
      assign b_in[gi]          = b_all[gi*WIDTH +: WIDTH];
      assign y[gi*SW +: SW]    = y_q[gi];
    end
  endgenerate

`ifdef MAC_SCHED_RELU_EN
  // Negative results are clamped to zero at store time.
  assign store_val = mac_sum[SW-1] ? '0 : mac_sum;
`else
  assign store_val = mac_sum;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    mac_start_d = 1'b0;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    x_d         = x_q;
    w_d         = w_q;
    b_d         = b_q;
    y_d         = y_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d         = x;
          w_d         = w_in;
          b_d         = b_in;
          idx_d       = '0;
          for (int i = 0; i < M; i++) begin
            y_d[i] = '0;
          end
          state_d     = S_START;
          mac_start_d = 1'b1;
          in_ready_d  = 1'b0;
          busy_d      = 1'b1;
        end
      end

      S_START: begin
        // mac_start is high for this one cycle only; the MAC clears its
        // done flag on start, so the first WAIT cycle always sees done low.
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (mac_done) begin
          y_d[idx_q] = store_val;
          if (idx_q == LAST_IDX) begin
            state_d     = S_OUT;
            out_valid_d = 1'b1;
          end else begin
            idx_d       = idx_q + IW'(1);
            state_d     = S_START;
            mac_start_d = 1'b1;
          end
        end
      end

      S_OUT: begin
        // Return to IDLE with in_ready raised. The next job can therefore
        // only be taken one cycle after the output handshake.
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      mac_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      x_q         <= '0;
      for (int i = 0; i < M; i++) begin
        w_q[i] <= '0;
        b_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      mac_start_q <= mac_start_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      x_q         <= x_d;
      w_q         <= w_d;
      b_q         <= b_d;
      y_q         <= y_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mac_start = mac_start_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign mac_x     = x_q;
  assign mac_w     = w_q[idx_q];
  assign mac_b     = b_q[idx_q];

endmodule

// File: tb/tb_mac_layer_sched.sv
// -----------------------------------------------------------------------------
// tb_mac_layer_sched
//
// Testbench for mac_layer_sched with N=4, WIDTH=8, M=2. It contains a
// behavioural sequential MAC with a start/done handshake and a latency of
// N+2 cycles per neuron as seen by the scheduler. When a job is accepted,
// the expected layer result is computed directly from the input vectors and
// pushed onto a queue. A monitor pops an entry whenever out_valid is
// presented and compares it against y. The monitor also checks latency,
// the mac_start count, the hold behaviour and in_ready.
// -----------------------------------------------------------------------------
module tb_mac_layer_sched;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int M  = 2;
  localparam int SW = 2*W + 2;
  localparam int LAT = M*(N+2);

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [N*W-1:0]      x;
  logic [M*N*W-1:0]    w_all;
  logic [M*W-1:0]      b_all;
  logic                mac_start;
  logic [N*W-1:0]      mac_x;
  logic [N*W-1:0]      mac_w;
  logic [W-1:0]        mac_b;
  logic                mac_done;
  logic [SW-1:0]       mac_sum;
  logic                out_valid;
  logic                out_ready;
  logic [M*SW-1:0]     y;
  logic                busy;

  mac_layer_sched #(.N(N), .WIDTH(W), .M(M)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .w_all(w_all), .b_all(b_all),
    .mac_start(mac_start), .mac_x(mac_x), .mac_w(mac_w), .mac_b(mac_b),
    .mac_done(mac_done), .mac_sum(mac_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural MAC ----------------------------------------
  function automatic logic [SW-1:0] mac_fn(input logic [N*W-1:0] xv,
                                           input logic [N*W-1:0] wv,
                                           input logic [W-1:0] bv);
    int s;
    s = $signed(bv);
    for (int i = 0; i < N; i++) s += $signed(xv[i*W +: W]) * $signed(wv[i*W +: W]);
    return s[SW-1:0];
  endfunction

  int            mcnt;
  logic [SW-1:0] mpend;
  always @(posedge clk) begin
    if (rst) begin
      mac_done <= 1'b0;
      mac_sum  <= '0;
      mcnt     <= 0;
    end else if (mac_start) begin
      mac_done <= 1'b0;
      mcnt     <= N;
      mpend    <= mac_fn(mac_x, mac_w, mac_b);
    end else if (mcnt > 1) begin
      mcnt <= mcnt - 1;
    end else if (mcnt == 1) begin
      mcnt     <= 0;
      mac_done <= 1'b1;
      mac_sum  <= mpend;
    end
  end

  // ---------------- reference model ----------------------------------------
  function automatic logic [M*SW-1:0] ref_y(input logic [N*W-1:0] xv,
                                            input logic [M*N*W-1:0] wv,
                                            input logic [M*W-1:0] bv);
    logic [M*SW-1:0] r;
    int s;
    r = '0;
    for (int j = 0; j < M; j++) begin
      s = $signed(bv[j*W +: W]);
      for (int i = 0; i < N; i++)
        s += $signed(xv[i*W +: W]) * $signed(wv[(j*N+i)*W +: W]);
`ifdef MAC_SCHED_RELU_EN
      if (s < 0) s = 0;
`endif
      r[j*SW +: SW] = s[SW-1:0];
    end
    return r;
  endfunction

  logic [M*SW-1:0] exp_q[$];
  int              acc_q[$];

  // ---------------- monitor --------------------------------------------------
  bit              presented = 0;
  int              starts_since = 0;
  int              hs_cyc = 0;
  logic [M*SW-1:0] cur_exp = '0;
  int              acc_c;

  always @(negedge clk) begin
    if (rst) begin
      presented    = 0;
      starts_since = 0;
    end else begin
      if (mac_start) starts_since++;
      if (out_valid) begin
        if (!presented) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 64'(out_valid), 64'(0));
          end else begin
            cur_exp = exp_q.pop_front();
            acc_c   = acc_q.pop_front();
            $display("out: y=%0h expected=%0h latency=%0d", y, cur_exp, cyc - acc_c);
            chk("y", 64'(y), 64'(cur_exp));
            chk("latency", 64'(cyc - acc_c), 64'(LAT));
            chk("start_pulses", 64'(starts_since), 64'(M));
          end
          starts_since = 0;
          presented = 1;
        end else begin
          chk("y_hold", 64'(y), 64'(cur_exp));
        end
        chk("in_ready_in_out", 64'(in_ready), 64'(0));
        if (out_ready) begin
          presented = 0;
          hs_cyc    = cyc + 1;
        end
      end
    end
  end

  // ---------------- driver tasks (called just after a rising edge) --------
  task automatic issue_job(input logic [N*W-1:0] xv, input logic [M*N*W-1:0] wv,
                           input logic [M*W-1:0] bv, input bit keep_valid,
                           output int acc);
    bit got, r;
    got = 0;
    acc = 0;
    x = xv; w_all = wv; b_all = bv;
    in_valid = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        got = 1;
        break;
      end
    end
    if (got) begin
      acc = cyc;
      exp_q.push_back(ref_y(xv, wv, bv));
      acc_q.push_back(cyc);
      $display("in: x=%0h w=%0h b=%0h accepted cycle %0d", xv, wv, bv, cyc);
    end else begin
      chk("accept_timeout", 64'(0), 64'(1));
    end
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit rand_rdy);
    bit hs, got;
    got = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      hs = out_valid && out_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        got = 1;
        break;
      end
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
    if (!got) chk("output_timeout", 64'(0), 64'(1));
    out_ready = 1'b1;
  endtask

  // ---------------- stimulus -------------------------------------------------
  logic [N*W-1:0]   x1, x2, xb;
  logic [M*N*W-1:0] w1, w2;
  logic [M*W-1:0]   b1, b2;
  int               acc, acc_b;
  bit               seen;

  initial begin
    // Test 1 vectors: x=[1,2,3,4], w0=[1,1,1,1], b0=5, w1=[-1..], b1=0
    x1 = {8'sd4, 8'sd3, 8'sd2, 8'sd1};
    w1 = {{4{8'hFF}}, {4{8'h01}}};
    b1 = {8'd0, 8'd5};
    // Test 2 vectors: every operand at the negative extreme, positive bias
    x2 = {4{8'h80}};
    w2 = {8{8'h80}};
    b2 = {8'h7F, 8'h7F};
    xb = {8'sd7, -8'sd3, 8'sd9, -8'sd1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; w_all = '0; b_all = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_y", 64'(y), 64'(0));
    chk("rst_mac_start", 64'(mac_start), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;

    // Test 1: basic job
    issue_job(x1, w1, b1, 0, acc);
    wait_done(0);

    // Test 2: extreme operands, full 18-bit result
    issue_job(x2, w2, b2, 0, acc);
    wait_done(0);

    // Test 3: backpressure with a second request while holding
    out_ready = 1'b0;
    issue_job(x1, w1, b1, 0, acc);
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("hold_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    x = xb; w_all = w2; b_all = b2; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_out_valid", 64'(out_valid), 64'(1));
      chk("hold_in_ready", 64'(in_ready), 64'(0));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_done(0);
    repeat (20) @(posedge clk);
    #1;
    chk("no_extra_job", 64'(exp_q.size()), 64'(0));
    chk("idle_after_hold", 64'(busy), 64'(0));

    // Test 4: reset in the second WAIT cycle of neuron 0
    issue_job(x1, w1, b1, 0, acc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wait2_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_y", 64'(y), 64'(0));
    chk("abort_mac_start", 64'(mac_start), 64'(0));
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    issue_job(x2, w1, b2, 0, acc);
    wait_done(0);

    // Test 5: back-to-back jobs, in_valid held high
    issue_job(x1, w1, b1, 1, acc);
    issue_job(xb, w2, b1, 0, acc_b);
    chk("b2b_gap", 64'(acc_b - hs_cyc), 64'(1));
    wait_done(0);

    // Randomized jobs with random backpressure
    for (int k = 0; k < 20; k++) begin
      issue_job($urandom, {$urandom, $urandom}, 16'($urandom), 0, acc);
      wait_done(1);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

endmodule
